// File: rtl/mac_seq_ctrl_if.sv
// Bundle of signals between the dot-product sequencer, its requester and the
// shared mac datapath. "slave" is the sequencer's view; "master" is the
// surrounding logic (requester plus mac instance).
interface mac_seq_ctrl_if #(
  parameter int DW    = 12,
  parameter int AW    = 25,
  parameter int LEN_W = 8
);
  // command / status
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  // operand stream
  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  // mac datapath
  logic [DW-1:0]    mac_ain;
  logic [DW-1:0]    mac_bin;
  logic             mac_clr;
  logic [AW-1:0]    mac_out;
  // result stream
  logic             res_valid;
  logic             res_ready;
  logic [AW-1:0]    res_data;

  modport master (
    output start, len, op_valid, op_a, op_b, mac_out, res_ready,
    input  busy, op_ready, mac_ain, mac_bin, mac_clr, res_valid, res_data
  );

  modport slave (
    input  start, len, op_valid, op_a, op_b, mac_out, res_ready,
    output busy, op_ready, mac_ain, mac_bin, mac_clr, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: clears the mac, streams len operand pairs into it,
// waits out the mac pipeline, then hands the captured sum to the requester.
// Idle cycles inside a run drive zero operands so the accumulator holds.
module mac_seq_ctrl #(
  parameter int DW      = 12,
  parameter int AW      = 25,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input logic           clk,
  input logic           reset,   // asynchronous, active low
  mac_seq_ctrl_if.slave bus
);

  localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [LEN_W-1:0]   beat_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [DW-1:0]      ain_reg;
  logic [DW-1:0]      bin_reg;
  logic [AW-1:0]      res_data_reg;

  logic xfer;
  logic last_beat;
  logic drain_done;

  // op_ready is exactly (state == RUN), so a transfer is RUN plus op_valid
  assign xfer       = (state_reg == RUN) && bus.op_valid;
  assign last_beat  = xfer && (beat_cnt_reg == LEN_W'(1));
  assign drain_done = (drain_cnt_reg == DRAIN_W'(0));

  assign bus.mac_ain  = ain_reg;
  assign bus.mac_bin  = bin_reg;
  assign bus.res_data = res_data_reg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; start is only looked at while idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.len != '0) ? CLR : DONE;
        end
      end
      CLR:   state_next = RUN;
      RUN: begin
        if (last_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and mac-clear outputs decoded straight from the state
  always_comb begin
    bus.busy      = 1'b1;
    bus.op_ready  = 1'b0;
    bus.mac_clr   = 1'b0;
    bus.res_valid = 1'b0;
    case (state_reg)
      IDLE:    bus.busy      = 1'b0;
      CLR:     bus.mac_clr   = 1'b1;
      RUN:     bus.op_ready  = 1'b1;
      DONE:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand drive to the mac: accepted pair for one cycle, zero otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ain_reg <= '0;
      bin_reg <= '0;
    end else if (xfer) begin
      ain_reg <= bus.op_a;
      bin_reg <= bus.op_b;
    end else begin
      ain_reg <= '0;
      bin_reg <= '0;
    end
  end

  // Beat counter: loaded from len at start, counts accepted pairs down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start && (bus.len != '0)) begin
      beat_cnt_reg <= bus.len;
    end else if (xfer) begin
      beat_cnt_reg <= beat_cnt_reg - LEN_W'(1);
    end
  end

  // Drain counter: covers the mac latency after the last pair goes in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_reg <= '0;
    end else if (last_beat) begin
      drain_cnt_reg <= DRAIN_W'(MAC_LAT);
    end else if ((state_reg == DRAIN) && !drain_done) begin
      drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
    end
  end

  // Result capture: zero for an empty vector, mac sum once fully drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start && (bus.len == '0)) begin
      res_data_reg <= '0;
    end else if ((state_reg == DRAIN) && drain_done) begin
      res_data_reg <= bus.mac_out;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural mac closes the loop, a table of
// dot-product runs is replayed, and results are matched against a queue of
// expected sums. Corner cases (empty vector, abort by reset) are hand-coded.
module tb_mac_seq_ctrl;
  localparam int DW      = 12;
  localparam int AW      = 25;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  typedef struct packed {
    logic [7:0]        len;
    logic [3:0][11:0]  a;
    logic [3:0][11:0]  b;
    logic [3:0]        gap;
    logic [3:0]        hold;
    logic [24:0]       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

  mac_seq_ctrl #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural mac: accumulates Ain*Bin every clock unless cleared
  logic [AW-1:0] acc = '0;
  always @(posedge clk) begin
    if (bus.mac_clr) acc <= '0;
    else             acc <= acc + AW'(bus.mac_ain) * AW'(bus.mac_bin);
  end
  assign bus.mac_out = acc;

  // Running counts of cycles with mac_clr / op_ready high
  int clr_cnt = 0;
  int rdy_cnt = 0;
  always @(negedge clk) begin
    if (bus.mac_clr)  clr_cnt <= clr_cnt + 1;
    if (bus.op_ready) rdy_cnt <= rdy_cnt + 1;
  end

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] sb_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input int a3,
                              input int b3, input int gap, input int hold, input int exp);
    vec_t v;
    v.len  = 8'(len);
    v.a[0] = 12'(a0); v.b[0] = 12'(b0);
    v.a[1] = 12'(a1); v.b[1] = 12'(b1);
    v.a[2] = 12'(a2); v.b[2] = 12'(b2);
    v.a[3] = 12'(a3); v.b[3] = 12'(b3);
    v.gap  = 4'(gap);
    v.hold = 4'(hold);
    v.exp  = 25'(exp);
    return v;
  endfunction

  // One complete run: start, stream pairs, wait for result, handshake it
  task automatic run_vec(input vec_t v);
    int cyc;
    int budget;
    int n;
    int lat;
    logic [AW-1:0] want;
    n = int'(v.len);
    bus.start = 1'b1;
    bus.len   = v.len;
    sb_q.push_back(v.exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    if (n != 0) begin
      check("clr_pulse", bus.mac_clr, 1);
      check("ready_in_clr", bus.op_ready, 0);
    end
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = v.a[i];
      bus.op_b     = v.b[i];
      budget = 0;
      while (!bus.op_ready && budget < 20) begin
        @(posedge clk); #1;
        cyc++;
        budget++;
      end
      check("op_ready_wait", bus.op_ready, 1);
      @(posedge clk); #1;
      cyc++;
      bus.op_valid = 1'b0;
      check("mac_ain", bus.mac_ain, v.a[i]);
      check("mac_bin", bus.mac_bin, v.b[i]);
      if (i < n - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          @(posedge clk); #1;
          cyc++;
          check("gap_ain", bus.mac_ain, 0);
          check("gap_bin", bus.mac_bin, 0);
          check("gap_ready", bus.op_ready, 1);
        end
      end
    end
    budget = 0;
    while (!bus.res_valid && budget < 50) begin
      @(posedge clk); #1;
      cyc++;
      budget++;
    end
    check("res_valid", bus.res_valid, 1);
    lat = (n == 0) ? 1 : n + MAC_LAT + 3 + int'(v.gap) * (n - 1);
    check("latency", cyc, lat);
    for (int h = 0; h < int'(v.hold); h++) begin
      if (h == 1) begin
        bus.start = 1'b1;
        bus.len   = 8'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, v.exp);
      check("hold_busy", bus.busy, 1);
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      want = sb_q.pop_front();
      check("res_data", bus.res_data, want);
    end
    $display("run len=%0d result=%0d expected=%0d latency=%0d", n, bus.res_data, v.exp, cyc);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("valid_drop", bus.res_valid, 0);
    check("busy_drop", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_op_ready"}, bus.op_ready, 0);
    check({tag, "_mac_ain"}, bus.mac_ain, 0);
    check({tag, "_mac_bin"}, bus.mac_bin, 0);
    check({tag, "_mac_clr"}, bus.mac_clr, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr0;
    int rdy0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;

    tbl[0] = mk(3, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 44);
    tbl[1] = mk(3, 1, 2, 3, 4, 5, 6, 0, 0, 2, 0, 44);
    tbl[2] = mk(2, 4095, 4095, 4095, 4095, 0, 0, 0, 0, 0, 5, 33538050);
    tbl[3] = mk(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    tbl[4] = mk(1, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 100);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // table runs; the last two are back to back
    for (int k = 0; k < 5; k++) begin
      run_vec(tbl[k]);
    end

    // empty vector: straight to result, mac untouched
    clr0 = clr_cnt;
    rdy0 = rdy_cnt;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("len0_no_clr", clr_cnt - clr0, 0);
    check("len0_no_ready", rdy_cnt - rdy0, 0);

    // abort during RUN after one of four pairs
    bus.start = 1'b1;
    bus.len   = 8'd4;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_a     = 12'd5;
    bus.op_b     = 12'd5;
    @(posedge clk); #1;
    check("abort_ready", bus.op_ready, 1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    check("abort_ain", bus.mac_ain, 5);
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("abort");
    $display("run aborted by reset busy=%0d", bus.busy);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_abort");

    // fresh run must not see the stale accumulation
    run_vec(mk(1, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 63));

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
